uart_tx_scheduler: RTL and testbench

UART_TX_SCHEDULER -- requirements
Module: uart_tx_scheduler

---
 rtl/uart_ctrl_pkg.sv | 31 +++
 rtl/uart_tx_shifter.sv | 79 +++++++
 rtl/uart_tx_scheduler.sv | 143 ++++++++++++++
 tb/tb_uart_tx_scheduler.sv | 204 ++++++++++++++++++++
 4 files changed

// File: rtl/uart_ctrl_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : uart_ctrl_pkg
//  Description : Shared types and helpers for the UART transmit scheduler.
//                The parity state and parity helper exist only when
//                UART_TX_PARITY_EN is defined.
//  Revision    : 1.0 - initial release
// ============================================================================
package uart_ctrl_pkg;

   localparam int DATA_W = 8;

   typedef enum logic [2:0] {
      S_IDLE   = 3'd0,
      S_START  = 3'd1,
      S_DATA   = 3'd2,
`ifdef UART_TX_PARITY_EN
      S_PARITY = 3'd3,
`endif
      S_STOP   = 3'd4
   } state_t;

`ifdef UART_TX_PARITY_EN
   // Even parity: the parity bit makes the total count of ones even.
   function automatic logic even_parity(input logic [DATA_W-1:0] i_d);
      return ^i_d;
   endfunction
`endif

endpackage
`default_nettype wire

// File: rtl/uart_tx_shifter.sv
`default_nettype none
// ============================================================================
//  Module      : uart_tx_shifter
//  Description : Baud counter, bit counter and shift register for one UART
//                frame. Parity latch present only with UART_TX_PARITY_EN.
//  Revision    : 1.0 - initial release
// ============================================================================
module uart_tx_shifter
   import uart_ctrl_pkg::*;
#(
   parameter int CLKS_PER_BIT = 868
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              i_load,
   input  logic [DATA_W-1:0] i_data,
   input  logic              i_run,
   input  logic              i_shift,
   output logic              o_tick,
   output logic              o_last_bit,
`ifdef UART_TX_PARITY_EN
   output logic              o_parity,
`endif
   output logic              o_next_bit
);

   localparam int CNT_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
   localparam int BIT_W = $clog2(DATA_W);

   logic [CNT_W-1:0]  r_cnt;
   logic [BIT_W-1:0]  r_bit;
   logic [DATA_W-1:0] r_sh;

   assign o_tick     = (r_cnt == CNT_W'(CLKS_PER_BIT - 1));
   assign o_last_bit = (r_bit == BIT_W'(DATA_W - 1));
   // Bit that will be on the line after this edge: the shift exposes r_sh[1].
   assign o_next_bit = i_shift ? r_sh[1] : r_sh[0];

   // Every state lasts exactly one bit period, so wrapping on the tick
   // restarts the count at 0 on every state entry.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_cnt <= '0;
      end else if (!i_run || o_tick) begin
         r_cnt <= '0;
      end else begin
         r_cnt <= r_cnt + CNT_W'(1);
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_bit <= '0;
         r_sh  <= '0;
      end else if (i_load) begin
         r_bit <= '0;
         r_sh  <= i_data;
      end else if (i_shift) begin
         r_bit <= r_bit + BIT_W'(1);
         r_sh  <= {1'b0, r_sh[DATA_W-1:1]};
      end
   end

`ifdef UART_TX_PARITY_EN
   logic r_parity;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_parity <= 1'b0;
      end else if (i_load) begin
         r_parity <= even_parity(i_data);
      end
   end

   assign o_parity = r_parity;
`endif

endmodule
`default_nettype wire

// File: rtl/uart_tx_scheduler.sv
`default_nettype none
// ============================================================================
//  Module      : uart_tx_scheduler
//  Description : Two-requester round-robin UART transmitter with CTS flow
//                control. Define UART_TX_PARITY_EN to add an even parity bit.
//  Revision    : 1.0 - initial release
// ============================================================================
module uart_tx_scheduler
   import uart_ctrl_pkg::*;
#(
   parameter int CLKS_PER_BIT = 868
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              req0_valid,
   input  logic [DATA_W-1:0] req0_data,
   output logic              req0_ready,
   input  logic              req1_valid,
   input  logic [DATA_W-1:0] req1_data,
   output logic              req1_ready,
   input  logic              cts,
   output logic              tx,
   output logic              busy,
   output logic              grant_id
);

   state_t            r_state;
   state_t            w_state_next;
   logic              r_cts_meta;
   logic              r_cts_s;
   logic              r_last;
   logic              r_grant;
   logic              r_tx;
   logic              w_tx_next;
   logic              w_win_id;
   logic              w_accept;
   logic              w_tick;
   logic              w_last_bit;
   logic              w_next_bit;
   logic              w_shift;
   logic [DATA_W-1:0] w_win_data;
`ifdef UART_TX_PARITY_EN
   logic              w_parity;
`endif

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_cts_meta <= 1'b0;
         r_cts_s    <= 1'b0;
      end else begin
         r_cts_meta <= cts;
         r_cts_s    <= r_cts_meta;
      end
   end

   // Round-robin: on a tie the requester not granted last wins.
   always_comb begin
      w_win_id = 1'b0;
      if (req0_valid && req1_valid) begin
         w_win_id = ~r_last;
      end else if (req1_valid) begin
         w_win_id = 1'b1;
      end
   end

   assign w_accept   = (r_state == S_IDLE) && r_cts_s && (req0_valid || req1_valid);
   assign req0_ready = w_accept && !w_win_id;
   assign req1_ready = w_accept &&  w_win_id;
   assign w_win_data = w_win_id ? req1_data : req0_data;
   assign w_shift    = (r_state == S_DATA) && w_tick;

   uart_tx_shifter #(
      .CLKS_PER_BIT (CLKS_PER_BIT)
   ) u_shifter (
      .clk        (clk),
      .rst        (rst),
      .i_load     (w_accept),
      .i_data     (w_win_data),
      .i_run      (r_state != S_IDLE),
      .i_shift    (w_shift),
      .o_tick     (w_tick),
      .o_last_bit (w_last_bit),
`ifdef UART_TX_PARITY_EN
      .o_parity   (w_parity),
`endif
      .o_next_bit (w_next_bit)
   );

   always_comb begin
      w_state_next = r_state;
      w_tx_next    = 1'b1;
      case (r_state)
         S_IDLE:   if (w_accept) w_state_next = S_START;
         S_START:  if (w_tick)   w_state_next = S_DATA;
         S_DATA: begin
            if (w_tick && w_last_bit) begin
`ifdef UART_TX_PARITY_EN
               w_state_next = S_PARITY;
`else
               w_state_next = S_STOP;
`endif
            end
         end
`ifdef UART_TX_PARITY_EN
         S_PARITY: if (w_tick)   w_state_next = S_STOP;
`endif
         S_STOP:   if (w_tick)   w_state_next = S_IDLE;
         default:                w_state_next = S_IDLE;
      endcase

      // Line level is decoded from the next state so tx leaves a flop.
      case (w_state_next)
         S_START:  w_tx_next = 1'b0;
         S_DATA:   w_tx_next = w_next_bit;
`ifdef UART_TX_PARITY_EN
         S_PARITY: w_tx_next = w_parity;
`endif
         default:  w_tx_next = 1'b1;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state <= S_IDLE;
         r_tx    <= 1'b1;
         r_last  <= 1'b1;
         r_grant <= 1'b0;
      end else begin
         r_state <= w_state_next;
         r_tx    <= w_tx_next;
         if (w_accept) begin
            r_last  <= w_win_id;
            r_grant <= w_win_id;
         end
      end
   end

   assign tx       = r_tx;
   assign busy     = (r_state != S_IDLE);
   assign grant_id = r_grant;

endmodule
`default_nettype wire

// File: tb/tb_uart_tx_scheduler.sv
`default_nettype none
// ============================================================================
//  Module      : tb_uart_tx_scheduler
//  Description : Directed self-checking bench for uart_tx_scheduler, bit
//                period 4 clocks; follows UART_TX_PARITY_EN when defined.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_uart_tx_scheduler;

   localparam int CPB = 4;
`ifdef UART_TX_PARITY_EN
   localparam int NB = 11;
`else
   localparam int NB = 10;
`endif

   logic       clk = 1'b0;
   logic       rst;
   logic       req0_valid, req1_valid;
   logic [7:0] req0_data, req1_data;
   logic       req0_ready, req1_ready;
   logic       cts;
   logic       tx, busy, grant_id;

   int n_checks = 0;
   int n_fail   = 0;

   uart_tx_scheduler #(
      .CLKS_PER_BIT (CPB)
   ) dut (
      .clk        (clk),
      .rst        (rst),
      .req0_valid (req0_valid),
      .req0_data  (req0_data),
      .req0_ready (req0_ready),
      .req1_valid (req1_valid),
      .req1_data  (req1_data),
      .req1_ready (req1_ready),
      .cts        (cts),
      .tx         (tx),
      .busy       (busy),
      .grant_id   (grant_id)
   );

   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Called just after the accepting edge; walks the whole frame.
   task automatic check_frame(input logic [7:0] d, input logic gid,
                              input int drop_at, input string tag);
      logic [10:0] bits;
      bits[0] = 1'b0;
      for (int i = 0; i < 8; i++) bits[i+1] = d[i];
`ifdef UART_TX_PARITY_EN
      bits[9]  = ^d;
      bits[10] = 1'b1;
`else
      bits[9]  = 1'b1;
      bits[10] = 1'b1;
`endif
      for (int c = 0; c < NB*CPB; c++) begin
         if (c == drop_at) cts = 1'b0;
         chk($sformatf("%s tx c%0d", tag, c), tx, bits[c/CPB]);
         chk($sformatf("%s busy c%0d", tag, c), busy, 1);
         chk($sformatf("%s ready c%0d", tag, c), {req0_ready, req1_ready}, 0);
         tick();
      end
      chk({tag, " end busy"}, busy, 0);
      chk({tag, " end tx"}, tx, 1);
      chk({tag, " grant"}, grant_id, gid);
   endtask

   initial begin
      rst = 1'b1; cts = 1'b0;
      req0_valid = 1'b1; req1_valid = 1'b0;
      req0_data = 8'hA5; req1_data = 8'h00;
      tick(); tick();
      chk("rst tx", tx, 1);
      chk("rst busy", busy, 0);
      chk("rst ready0", req0_ready, 0);
      chk("rst ready1", req1_ready, 0);
      chk("rst grant", grant_id, 0);

      // Out of reset, cts low: request must wait.
      rst = 1'b0;
      tick(); tick(); tick();
      chk("cts0 ready0", req0_ready, 0);

      // cts rises: two synchronizer edges before ready.
      cts = 1'b1;
      tick();
      chk("sync1 ready0", req0_ready, 0);
      tick();
      chk("sync2 ready0", req0_ready, 1);
      chk("sync2 ready1", req1_ready, 0);
      tick();
      req0_valid = 1'b0;
      check_frame(8'hA5, 1'b0, -1, "f_a5");

      // Both requesters valid: alternation starting with req1.
      req0_data = 8'h11; req1_data = 8'h22;
      req0_valid = 1'b1; req1_valid = 1'b1;
      #1;
      for (int k = 0; k < 3; k++) begin
         logic id;
         id = (k == 1) ? 1'b0 : 1'b1;
         chk($sformatf("rr%0d idle busy", k), busy, 0);
         chk($sformatf("rr%0d ready0", k), req0_ready, !id);
         chk($sformatf("rr%0d ready1", k), req1_ready, id);
         tick();
         if (k == 2) begin
            req0_valid = 1'b0; req1_valid = 1'b0;
         end
         check_frame(id ? 8'h22 : 8'h11, id, -1, $sformatf("rr%0d", k));
      end

      // Flow control: cts low holds the request off.
      cts = 1'b0;
      tick(); tick(); tick();
      req1_valid = 1'b1; req1_data = 8'h3C;
      #1;
      for (int i = 0; i < 100; i++) begin
         chk($sformatf("hold ready1 %0d", i), req1_ready, 0);
         chk($sformatf("hold busy %0d", i), busy, 0);
         chk($sformatf("hold tx %0d", i), tx, 1);
         tick();
      end
      cts = 1'b1;
      for (int i = 0; i < 3; i++) begin
         if (req1_ready) break;
         tick();
      end
      chk("cts resume ready1", req1_ready, 1);
      tick();
      req1_valid = 1'b0;
      check_frame(8'h3C, 1'b1, -1, "f_3c");

      // cts dropped during data bit 3: frame completes, then no acceptance.
      req0_valid = 1'b1; req0_data = 8'hFF;
      #1;
      chk("ff ready0", req0_ready, 1);
      tick();
      check_frame(8'hFF, 1'b0, 16, "f_ff");
      for (int i = 0; i < 5; i++) begin
         chk($sformatf("ctsdrop ready0 %0d", i), req0_ready, 0);
         chk($sformatf("ctsdrop busy %0d", i), busy, 0);
         tick();
      end

      // Reset pulse in data bit 5 of a 0x00 frame.
      req0_valid = 1'b0;
      cts = 1'b1;
      tick(); tick();
      req0_valid = 1'b1; req0_data = 8'h00;
      #1;
      chk("z ready0", req0_ready, 1);
      tick();
      req0_valid = 1'b0;
      repeat (25) tick();
      chk("z bit5 tx", tx, 0);
      chk("z bit5 busy", busy, 1);
      #2 rst = 1'b1;
      #1;
      chk("midrst tx", tx, 1);
      chk("midrst busy", busy, 0);
      chk("midrst ready0", req0_ready, 0);
      tick(); tick();
      rst = 1'b0;
      req0_valid = 1'b1; req1_valid = 1'b1;
      req0_data = 8'h07; req1_data = 8'h40;
      #1;
      chk("postrst sync ready0", req0_ready, 0);
      tick(); tick();
      chk("postrst tie ready0", req0_ready, 1);
      chk("postrst tie ready1", req1_ready, 0);
      tick();
      req0_valid = 1'b0; req1_valid = 1'b0;
      check_frame(8'h07, 1'b0, -1, "f_07");

      req0_valid = 1'b1; req0_data = 8'h03;
      #1;
      chk("f03 ready0", req0_ready, 1);
      tick();
      req0_valid = 1'b0;
      check_frame(8'h03, 1'b0, -1, "f_03");

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
`default_nettype wire
